// File: rtl/syn_pcm_frame_buf.sv
// syn_pcm_frame_buf: multi-channel PCM capture buffer with two ping-pong banks.
// Each accepted sample set writes every channel at the same (bank, address).
// A completed bank raises its one-hot ready bit and stays untouched until it is
// acknowledged. The block supports continuous and single-shot capture, and it
// keeps a sticky overflow flag and a saturating count of dropped sample sets.
module syn_pcm_frame_buf #(
  parameter int NUM_CHNNLS   = 2,
  parameter int PCM_DATA_W   = 32,
  parameter int FRAME_ADDR_W = 7,
  parameter int DROP_CNT_W   = 16,
  localparam int CH_W        = (NUM_CHNNLS > 1) ? $clog2(NUM_CHNNLS) : 1
) (
  input  logic                             clk_ir,
  input  logic                             rst_ih,
  input  logic                             cfg_en_i,
  input  logic                             cfg_mode_i,
  input  logic                             pcm_valid_i,
  input  logic [NUM_CHNNLS*PCM_DATA_W-1:0] pcm_data_i,
  input  logic                             rd_en_i,
  input  logic                             rd_bank_i,
  input  logic [CH_W-1:0]                  rd_chnnl_i,
  input  logic [FRAME_ADDR_W-1:0]          rd_addr_i,
  output logic [PCM_DATA_W-1:0]            rd_data_o,
  output logic                             rd_valid_o,
  output logic [1:0]                       frame_rdy_oh_o,
  input  logic [1:0]                       frame_ack_i,
  output logic                             ovrflw_o,
  input  logic                             ovrflw_clr_i,
  output logic [DROP_CNT_W-1:0]            drop_cnt_o,
  output logic                             busy_o
);

  localparam int                    MEM_WORDS = 2 ** (FRAME_ADDR_W + 1);
  localparam logic [FRAME_ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [FRAME_ADDR_W-1:0] ADDR_ONE  = FRAME_ADDR_W'(1'b1);
  localparam logic [DROP_CNT_W-1:0]   DROP_ONE  = DROP_CNT_W'(1'b1);
  localparam logic [DROP_CNT_W-1:0]   DROP_MAX  = '1;
  localparam logic [CH_W:0]           NCH       = (CH_W + 1)'(NUM_CHNNLS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_wr_bank;
  logic [FRAME_ADDR_W-1:0] r_wr_addr;
  logic                    r_mode;
  logic                    r_busy;
  logic [1:0]              r_frame_rdy;
  logic                    r_ovrflw;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [PCM_DATA_W-1:0]   r_rd_data;
  logic                    r_rd_valid;

  logic [1:0]              w_free;
  logic                    w_free_cur;
  logic                    w_free_oth;
  logic                    w_last;
  logic                    w_wr_en;
  logic                    w_frame_done;
  logic                    w_drop;
  logic [1:0]              w_set_oh;
  logic [FRAME_ADDR_W:0]   w_wr_idx;
  logic [FRAME_ADDR_W:0]   w_rd_idx;
  logic                    w_chnnl_ok;
  logic [PCM_DATA_W-1:0]   w_ch_word [NUM_CHNNLS];

  // A bank is free when it is not holding a frame or is being acked right now
  assign w_free       = ~r_frame_rdy | frame_ack_i;
  assign w_free_cur   = w_free[r_wr_bank];
  assign w_free_oth   = w_free[~r_wr_bank];
  assign w_last       = (r_wr_addr == ADDR_MAX);
  assign w_wr_en      = cfg_en_i & pcm_valid_i &
                        ((r_state == ST_FILL) | ((r_state == ST_STALL) & w_free_cur));
  assign w_frame_done = w_wr_en & (r_state == ST_FILL) & w_last;
  assign w_drop       = cfg_en_i & pcm_valid_i & (r_state == ST_STALL) & ~w_free_cur;
  assign w_set_oh     = r_wr_bank ? 2'b10 : 2'b01;
  assign w_wr_idx     = {r_wr_bank, r_wr_addr};
  assign w_rd_idx     = {rd_bank_i, rd_addr_i};
  assign w_chnnl_ok   = ({1'b0, rd_chnnl_i} < NCH);

  // One storage array per channel; all channels share the write strobe and index
  for (genvar g = 0; g < NUM_CHNNLS; g++) begin : g_ch
    logic [PCM_DATA_W-1:0] r_mem [MEM_WORDS];

    // Sample storage write, intentionally without reset
    always_ff @(posedge clk_ir) begin
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= pcm_data_i[g*PCM_DATA_W +: PCM_DATA_W];
      end
    end

    assign w_ch_word[g] = r_mem[w_rd_idx];
  end

  // Capture FSM: owns the write pointer, the bank toggling and the busy flag
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_state   <= ST_IDLE;
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_mode    <= 1'b0;
      r_busy    <= 1'b0;
    end else if (!cfg_en_i) begin
      // Abort: drop the partial frame but keep the bank selection
      r_state   <= ST_IDLE;
      r_wr_addr <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mode    <= cfg_mode_i;
          r_wr_addr <= '0;
          r_busy    <= 1'b1;
          r_state   <= w_free_cur ? ST_FILL : ST_STALL;
        end
        ST_FILL: begin
          if (w_wr_en) begin
            if (w_last) begin
              r_wr_bank <= ~r_wr_bank;
              r_wr_addr <= '0;
              if (r_mode) begin
                r_state <= ST_HOLD;
              end else begin
                r_state <= w_free_oth ? ST_FILL : ST_STALL;
              end
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_ONE;
            end
          end
        end
        ST_STALL: begin
          if (w_free_cur) begin
            r_state <= ST_FILL;
            if (w_wr_en) begin
              r_wr_addr <= ADDR_ONE;
            end
          end
        end
        ST_HOLD: begin
          // Wait for the frame just completed (the other bank) to be released
          if (w_free_oth) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_wr_addr <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Frame-ready flags: acks clear, completion of the write bank sets
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_frame_rdy <= 2'b00;
    end else if (w_frame_done) begin
      r_frame_rdy <= (r_frame_rdy & ~frame_ack_i) | w_set_oh;
    end else begin
      r_frame_rdy <= r_frame_rdy & ~frame_ack_i;
    end
  end

  // Overflow accounting; a drop in the same cycle as a clear wins
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_ovrflw   <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovrflw <= 1'b1;
      if (ovrflw_clr_i) begin
        r_drop_cnt <= DROP_ONE;
      end else if (r_drop_cnt != DROP_MAX) begin
        r_drop_cnt <= r_drop_cnt + DROP_ONE;
      end
    end else if (ovrflw_clr_i) begin
      r_ovrflw   <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Read port: one-cycle registered read, out-of-range channel returns zero
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (rd_en_i) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_chnnl_ok ? w_ch_word[rd_chnnl_i] : '0;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_data_o      = r_rd_data;
  assign rd_valid_o     = r_rd_valid;
  assign frame_rdy_oh_o = r_frame_rdy;
  assign ovrflw_o       = r_ovrflw;
  assign drop_cnt_o     = r_drop_cnt;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_syn_pcm_frame_buf.sv
// Directed bench for syn_pcm_frame_buf with a depth-8, two-channel configuration.
module tb_syn_pcm_frame_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        cfg_mode;
  logic        pcm_valid;
  logic [63:0] pcm_data;
  logic        rd_en;
  logic        rd_bank;
  logic        rd_chnnl;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  frame_rdy;
  logic [1:0]  frame_ack;
  logic        ovrflw;
  logic        ovrflw_clr;
  logic [15:0] drop_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  syn_pcm_frame_buf #(
    .NUM_CHNNLS  (2),
    .PCM_DATA_W  (32),
    .FRAME_ADDR_W(3),
    .DROP_CNT_W  (16)
  ) dut (
    .clk_ir        (clk),
    .rst_ih        (rst),
    .cfg_en_i      (cfg_en),
    .cfg_mode_i    (cfg_mode),
    .pcm_valid_i   (pcm_valid),
    .pcm_data_i    (pcm_data),
    .rd_en_i       (rd_en),
    .rd_bank_i     (rd_bank),
    .rd_chnnl_i    (rd_chnnl),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .frame_rdy_oh_o(frame_rdy),
    .frame_ack_i   (frame_ack),
    .ovrflw_o      (ovrflw),
    .ovrflw_clr_i  (ovrflw_clr),
    .drop_cnt_o    (drop_cnt),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe; consecutive calls give back-to-back strobes
  task automatic push(input logic [31:0] d0, input logic [31:0] d1);
    pcm_valid = 1'b1;
    pcm_data  = {d1, d0};
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic b, input logic c,
                        input logic [2:0] a, input logic [31:0] exp);
    rd_en    = 1'b1;
    rd_bank  = b;
    rd_chnnl = c;
    rd_addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk_eq({tag, "_vld"}, rd_valid, 1'b1);
    chk_eq(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_mode = 1'b0; pcm_valid = 1'b0; pcm_data = 64'd0;
    rd_en = 1'b0; rd_bank = 1'b0; rd_chnnl = 1'b0; rd_addr = 3'd0;
    frame_ack = 2'b00; ovrflw_clr = 1'b0;

    @(negedge clk);
    chk_eq("rst_rd_data", rd_data, 32'd0);
    chk_eq("rst_rd_valid", rd_valid, 1'b0);
    chk_eq("rst_rdy", frame_rdy, 2'b00);
    chk_eq("rst_ovrflw", ovrflw, 1'b0);
    chk_eq("rst_drop", drop_cnt, 16'd0);
    chk_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // 1: continuous fill of bank0
    cfg_mode = 1'b0; cfg_en = 1'b1;
    cyc(1);
    chk_eq("t1_busy", busy, 1'b1);
    for (int k = 0; k < 8; k++) begin
      push(32'(k), 32'h100 + 32'(k));
      if (k == 6) chk_eq("t1_rdy_pre", frame_rdy, 2'b00);
    end
    chk_eq("t1_rdy", frame_rdy, 2'b01);
    rd_chk("t1_rd_b0c1a5", 1'b0, 1'b1, 3'd5, 32'h105);
    cyc(1);
    chk_eq("t1_rd_vld_drop", rd_valid, 1'b0);

    // 2: ping-pong without ack, strobes 9..24
    for (int k = 8; k < 24; k++) begin
      push(32'(k), 32'h100 + 32'(k));
      if (k == 15) begin
        chk_eq("t2_rdy11", frame_rdy, 2'b11);
        chk_eq("t2_ovf_pre", ovrflw, 1'b0);
      end
    end
    chk_eq("t2_ovf", ovrflw, 1'b1);
    chk_eq("t2_drop", drop_cnt, 16'd8);
    chk_eq("t2_rdy", frame_rdy, 2'b11);
    rd_chk("t2_b0c0a2", 1'b0, 1'b0, 3'd2, 32'd2);
    rd_chk("t2_b0c1a7", 1'b0, 1'b1, 3'd7, 32'h107);
    rd_chk("t2_b1c0a3", 1'b1, 1'b0, 3'd3, 32'd11);

    // 3: ack during stall together with a strobe
    frame_ack = 2'b01;
    push(32'hAA, 32'h1AA);
    frame_ack = 2'b00;
    chk_eq("t3_rdy", frame_rdy, 2'b10);
    chk_eq("t3_drop", drop_cnt, 16'd8);
    push(32'hAB, 32'h1AB);
    chk_eq("t3_drop_fill", drop_cnt, 16'd8);
    rd_chk("t3_b0c0a0", 1'b0, 1'b0, 3'd0, 32'hAA);
    rd_chk("t3_b0c0a1", 1'b0, 1'b0, 3'd1, 32'hAB);
    rd_chk("t3_b0c1a2", 1'b0, 1'b1, 3'd2, 32'h102);

    // Clean up before single-shot
    cfg_en = 1'b0; frame_ack = 2'b11; ovrflw_clr = 1'b1;
    cyc(1);
    frame_ack = 2'b00; ovrflw_clr = 1'b0;
    chk_eq("t4_pre_busy", busy, 1'b0);
    chk_eq("t4_pre_rdy", frame_rdy, 2'b00);
    chk_eq("t4_pre_ovf", ovrflw, 1'b0);
    chk_eq("t4_pre_drop", drop_cnt, 16'd0);

    // 4: single-shot, 20 strobes
    cfg_mode = 1'b1; cfg_en = 1'b1;
    cyc(1);
    for (int k = 0; k < 20; k++) push(32'h200 + 32'(k), 32'h240 + 32'(k));
    chk_eq("t4_rdy", frame_rdy, 2'b01);
    chk_eq("t4_ovf", ovrflw, 1'b0);
    chk_eq("t4_drop", drop_cnt, 16'd0);
    chk_eq("t4_busy_hold", busy, 1'b1);
    rd_chk("t4_b0c0a7", 1'b0, 1'b0, 3'd7, 32'h207);
    rd_chk("t4_b0c1a0", 1'b0, 1'b1, 3'd0, 32'h240);
    rd_chk("t4_b1c0a3", 1'b1, 1'b0, 3'd3, 32'd11);
    frame_ack = 2'b01;
    cyc(1);
    frame_ack = 2'b00;
    chk_eq("t4_ack_rdy", frame_rdy, 2'b00);
    chk_eq("t4_ack_idle", busy, 1'b0);
    cyc(1);
    chk_eq("t4_restart", busy, 1'b1);
    for (int k = 0; k < 8; k++) push(32'h300 + 32'(k), 32'h340 + 32'(k));
    chk_eq("t4_rdy_b1", frame_rdy, 2'b10);
    rd_chk("t4_b1c0a0", 1'b1, 1'b0, 3'd0, 32'h300);
    rd_chk("t4_b1c0a3", 1'b1, 1'b0, 3'd3, 32'h303);

    // 5: abort mid-frame, then restart in the same bank
    cfg_en = 1'b0; cfg_mode = 1'b0; frame_ack = 2'b10;
    cyc(1);
    frame_ack = 2'b00;
    chk_eq("t5_rdy0", frame_rdy, 2'b00);
    cfg_en = 1'b1;
    cyc(1);
    for (int k = 0; k < 3; k++) push(32'h400 + 32'(k), 32'h440 + 32'(k));
    cfg_en = 1'b0;
    cyc(1);
    chk_eq("t5_abort_idle", busy, 1'b0);
    cfg_en = 1'b1;
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      push(32'h500 + 32'(k), 32'h540 + 32'(k));
      if (k == 6) chk_eq("t5_rdy_pre", frame_rdy, 2'b00);
    end
    chk_eq("t5_rdy", frame_rdy, 2'b01);
    rd_chk("t5_b0c0a0", 1'b0, 1'b0, 3'd0, 32'h500);
    rd_chk("t5_b0c0a2", 1'b0, 1'b0, 3'd2, 32'h502);
    rd_chk("t5_b1c0a0", 1'b1, 1'b0, 3'd0, 32'h300);
    for (int k = 0; k < 8; k++) push(32'h600 + 32'(k), 32'h640 + 32'(k));
    chk_eq("t5_rdy11", frame_rdy, 2'b11);

    // Saturation of the drop counter
    pcm_valid = 1'b1;
    repeat (65534) @(negedge clk);
    chk_eq("t5_drop_fffe", drop_cnt, 16'hFFFE);
    repeat (7) @(negedge clk);
    pcm_valid = 1'b0;
    chk_eq("t5_drop_sat", drop_cnt, 16'hFFFF);
    chk_eq("t5_ovf", ovrflw, 1'b1);
    ovrflw_clr = 1'b1; pcm_valid = 1'b1;
    @(negedge clk);
    ovrflw_clr = 1'b0; pcm_valid = 1'b0;
    chk_eq("t5_clr_drop_cnt", drop_cnt, 16'd1);
    chk_eq("t5_clr_drop_ovf", ovrflw, 1'b1);
    ovrflw_clr = 1'b1;
    cyc(1);
    ovrflw_clr = 1'b0;
    chk_eq("t5_clr_cnt", drop_cnt, 16'd0);
    chk_eq("t5_clr_ovf", ovrflw, 1'b0);

    // 6: async reset in the middle of a fill
    frame_ack = 2'b01;
    cyc(1);
    frame_ack = 2'b00;
    chk_eq("t6_rdy_pre", frame_rdy, 2'b10);
    for (int k = 0; k < 4; k++) push(32'h700 + 32'(k), 32'h740 + 32'(k));
    chk_eq("t6_busy_pre", busy, 1'b1);
    rd_chk("t6_b1c1a7", 1'b1, 1'b1, 3'd7, 32'h647);
    #2 rst = 1'b1;
    #1;
    chk_eq("t6_rst_rd_data", rd_data, 32'd0);
    chk_eq("t6_rst_rd_valid", rd_valid, 1'b0);
    chk_eq("t6_rst_rdy", frame_rdy, 2'b00);
    chk_eq("t6_rst_ovf", ovrflw, 1'b0);
    chk_eq("t6_rst_drop", drop_cnt, 16'd0);
    chk_eq("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      push(32'h800 + 32'(k), 32'h840 + 32'(k));
      if (k == 6) chk_eq("t6_rdy_pre_full", frame_rdy, 2'b00);
    end
    chk_eq("t6_rdy", frame_rdy, 2'b01);
    rd_chk("t6_b0c1a4", 1'b0, 1'b1, 3'd4, 32'h844);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
